// File: rtl/sqrt_sig_iter.sv
// sqrt_sig_iter: multicycle restoring digit-recurrence square-root significand engine.
//
// Takes an operand fraction (hidden 1 implicit) plus the LSB of its biased exponent and
// produces the unrounded root significand {root, sticky} for a downstream rounding stage.
// The root MSB is the hidden 1 and the LSB is the guard bit.
//
// Build option: define SQRT_ITER_RADIX4_EN to retire two root bits per cycle (two
// cascaded radix-2 steps). The result is bit-identical to the default radix-2 build.
//
// Ports:
//   clk, resetn      clock, asynchronous active-low reset
//   enable           global stall; low freezes all state and the handshake
//   in_valid/ready   operand handshake (a_sig, a_exp_lsb)
//   out_valid/ready  result handshake (z_sig_nr)
//   z_sig_nr         {root[sig_width+1:0], sticky}
module sqrt_sig_iter #(
  parameter int unsigned sig_width = 23,
  parameter int unsigned cnt_width = $clog2(sig_width + 3)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 enable,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [sig_width-1:0] a_sig,
  input  logic                 a_exp_lsb,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [sig_width+2:0] z_sig_nr
);

  localparam int unsigned RootW = sig_width + 2;
  localparam int unsigned RemW  = sig_width + 4;
  localparam int unsigned RadW  = 2 * RootW;
  localparam logic [cnt_width-1:0] StepsC = cnt_width'(RootW);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e               state_q, state_d;
  logic [cnt_width-1:0] cnt_q, cnt_d;
  logic [RadW-1:0]      rad_q, rad_d;
  logic [RemW-1:0]      rem_q, rem_d;
  logic [RootW-1:0]     root_q, root_d;
  logic                 out_valid_q, out_valid_d;
  logic [RootW:0]       z_q, z_d;

  // One restoring radix-2 step: returns {new_rem, new_root}.
  function automatic logic [RemW+RootW-1:0] rstep(input logic [RemW-1:0]  rem,
                                                  input logic [RootW-1:0] q,
                                                  input logic [1:0]       bits);
    logic [RemW+1:0] num;
    logic [RemW+1:0] sub;
    logic [RemW+1:0] diff;
    logic [RemW-1:0] rem_n;
    logic            bit_n;
    num  = {rem, bits};
    sub  = {2'b00, q, 2'b01};
    diff = num - sub;
    // Bounds of the recurrence keep both candidates within RemW bits.
    if (num >= sub) begin
      rem_n = diff[RemW-1:0];
      bit_n = 1'b1;
    end else begin
      rem_n = num[RemW-1:0];
      bit_n = 1'b0;
    end
    return {rem_n, q[RootW-2:0], bit_n};
  endfunction

  logic [RemW+RootW-1:0] s1, s2;
  logic [RadW-1:0]       load_rad;
  logic                  accept;

  always_comb begin
    // Odd exponent LSB (even unbiased exponent): R = m << (RootW); otherwise R = 2m << RootW.
    if (a_exp_lsb) load_rad = {1'b0, 1'b1, a_sig, {RootW{1'b0}}};
    else           load_rad = {1'b1, a_sig, {(RootW + 1){1'b0}}};
  end

  always_comb begin
    s1 = rstep(rem_q, root_q, rad_q[RadW-1 -: 2]);
    s2 = rstep(s1[RemW+RootW-1 -: RemW], s1[RootW-1:0], rad_q[RadW-3 -: 2]);
  end

  assign accept = enable && in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rad_d       = rad_q;
    rem_d       = rem_q;
    root_d      = root_q;
    out_valid_d = out_valid_q;
    z_d         = z_q;
    if (enable) begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            rad_d   = load_rad;
            rem_d   = '0;
            root_d  = '0;
            cnt_d   = '0;
            state_d = StCalc;
          end
        end
        StCalc: begin
`ifdef SQRT_ITER_RADIX4_EN
          if ((StepsC - cnt_q) >= cnt_width'(2)) begin
            rem_d  = s2[RemW+RootW-1 -: RemW];
            root_d = s2[RootW-1:0];
            rad_d  = {rad_q[RadW-5:0], 4'b0000};
            cnt_d  = cnt_q + cnt_width'(2);
          end else begin
            rem_d  = s1[RemW+RootW-1 -: RemW];
            root_d = s1[RootW-1:0];
            rad_d  = {rad_q[RadW-3:0], 2'b00};
            cnt_d  = cnt_q + cnt_width'(1);
          end
`else
          rem_d  = s1[RemW+RootW-1 -: RemW];
          root_d = s1[RootW-1:0];
          rad_d  = {rad_q[RadW-3:0], 2'b00};
          cnt_d  = cnt_q + cnt_width'(1);
`endif
          if (cnt_d == StepsC) begin
            state_d     = StDone;
            out_valid_d = 1'b1;
            z_d         = {root_d, |rem_d};
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            if (in_valid) begin
              // Result drains and a new operand loads in the same cycle.
              rad_d   = load_rad;
              rem_d   = '0;
              root_d  = '0;
              cnt_d   = '0;
              state_d = StCalc;
            end else begin
              state_d = StIdle;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rad_q       <= '0;
      rem_q       <= '0;
      root_q      <= '0;
      out_valid_q <= 1'b0;
      z_q         <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rad_q       <= rad_d;
      rem_q       <= rem_d;
      root_q      <= root_d;
      out_valid_q <= out_valid_d;
      z_q         <= z_d;
    end
  end

  // in_ready passes out_ready through while a result is waiting.
  assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
  assign out_valid = out_valid_q;
  assign z_sig_nr  = z_q;

  logic unused_accept;
  assign unused_accept = accept;

endmodule

// File: tb/tb_sqrt_sig_iter.sv
// Self-checking bench for sqrt_sig_iter: directed cases, backpressure, stall, reset abort
// and random operands against an independent bitwise floor(sqrt) model.
module tb_sqrt_sig_iter;

`ifdef SQRT_ITER_RADIX4_EN
  localparam int Lat = 13;
`else
  localparam int Lat = 25;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [22:0] a_sig = '0;
  logic        a_exp_lsb = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [25:0] z_sig_nr;

  int checks = 0;
  int failures = 0;
  logic [25:0] sb[$];

  always #5 clk = ~clk;

  sqrt_sig_iter #(.sig_width(23)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .enable    (enable),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_sig     (a_sig),
    .a_exp_lsb (a_exp_lsb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z_sig_nr  (z_sig_nr)
  );

  function automatic logic [25:0] ref_sqrt(input logic [22:0] a, input logic lsb);
    longint unsigned m, r, q, t;
    m = {40'd0, 1'b1, a};
    r = lsb ? (m << 25) : (m << 26);
    q = 0;
    for (int b = 24; b >= 0; b--) begin
      t = q | (64'd1 << b);
      if (t * t <= r) q = t;
    end
    return {q[24:0], (q * q != r)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: pop on every output transfer.
  always @(negedge clk) begin
    if (resetn && enable && out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_result", 64'(z_sig_nr), 64'h1_0000_0000);
      else chk("result", 64'(z_sig_nr), 64'(sb.pop_front()));
    end
  end

  // Drive one operand, wait for acceptance and then for out_valid, checking latency.
  // Optional stall: enable low for stall_len cycles starting stall_at cycles after accept.
  task automatic send(input logic [22:0] a, input logic lsb, input int exp_lat,
                      input int stall_at, input int stall_len);
    int lat;
    int budget;
    bit ok;
    in_valid  = 1'b1;
    a_sig     = a;
    a_exp_lsb = lsb;
    ok = 0;
    for (budget = 0; budget < 200; budget++) begin
      @(negedge clk);
      if (in_ready && enable) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      chk("accept_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    sb.push_back(ref_sqrt(a, lsb));
    lat = 0;
    ok = 0;
    while (lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (stall_len > 0 && lat == stall_at) enable = 1'b0;
      if (stall_len > 0 && lat == stall_at + stall_len) enable = 1'b1;
      @(negedge clk);
      if (out_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("result_timeout", 64'd0, 64'd1);
    else chk("latency", 64'(lat), 64'(exp_lat + stall_len));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [25:0] held;
    // Reset state
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_z", 64'(z_sig_nr), 64'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Directed values
    send(23'h000000, 1'b1, Lat, 0, 0);
    chk("sqrt1_const", 64'(ref_sqrt(23'h0, 1'b1)), 64'h2000000);
    send(23'h100000, 1'b0, Lat, 0, 0);
    chk("sqrt225_const", 64'(ref_sqrt(23'h100000, 1'b0)), 64'h3000000);
    send(23'h000000, 1'b0, Lat, 0, 0);
    chk("sqrt2_const", 64'(ref_sqrt(23'h0, 1'b0)), 64'h2D413CD);
    send(23'h7FFFFF, 1'b0, Lat, 0, 0);
    send(23'h7FFFFF, 1'b1, Lat, 0, 0);

    // Backpressure, then same-cycle drain and accept
    out_ready = 1'b0;
    send(23'h123456, 1'b1, Lat, 0, 0);
    held = ref_sqrt(23'h123456, 1'b1);
    repeat (10) begin
      @(negedge clk);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_z", 64'(z_sig_nr), 64'(held));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(23'h2AAAAA, 1'b0, Lat, 0, 0);

    // enable stall mid-CALC
    send(23'h3C0F0F, 1'b1, Lat, 6, 5);

    // Reset mid-CALC aborts
    in_valid = 1'b1;
    a_sig = 23'h555555;
    a_exp_lsb = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_z", 64'(z_sig_nr), 64'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    send(23'h555555, 1'b0, Lat, 0, 0);

    // Random operands
    for (int i = 0; i < 1000; i++) begin
      send(23'($urandom), 1'($urandom_range(0, 1)), Lat, 0, 0);
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
